// File: rtl/pipelined_carry_select_adder_if.sv
// pipelined_carry_select_adder_if: operand/result handshake bundle for the pipelined carry-select adder
interface pipelined_carry_select_adder_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, result, cout, overflow, zero
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, result, cout, overflow, zero
  );
endinterface

// File: rtl/pipelined_carry_select_adder.sv
// pipelined_carry_select_adder: carry-select add/sub, GPS groups per stage, registered carry between stages
module pipelined_carry_select_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4,
  parameter int GPS   = 2
) (
  input logic clk,
  input logic rst,
  pipelined_carry_select_adder_if.slave s
);
  localparam int NSTAGES = WIDTH / (BLOCK * GPS);
  logic             adv;
  logic [WIDTH-1:0] a_q [NSTAGES];
  logic [WIDTH-1:0] b_q [NSTAGES];
  logic [WIDTH-1:0] s_q [NSTAGES];
  logic [WIDTH-1:0] s_n [NSTAGES];
  logic             c_q [NSTAGES];
  logic             c_n [NSTAGES];
  logic             v_q [NSTAGES];
  assign adv        = !s.out_valid || s.out_ready;
  assign s.in_ready = adv;
  for (genvar k = 0; k < NSTAGES; k++) begin : st
    logic [BLOCK-1:0] gs [GPS];
    logic             gc [GPS+1];
    logic [WIDTH-1:0] sv;
    assign gc[0] = c_q[k];
    for (genvar g = 0; g < GPS; g++) begin : gr
      localparam int L = (k * GPS + g) * BLOCK;
      logic [BLOCK:0] s0, s1;
      assign s0 = {1'b0, a_q[k][L +: BLOCK]} + {1'b0, b_q[k][L +: BLOCK]};
      assign s1 = {1'b0, a_q[k][L +: BLOCK]} + {1'b0, b_q[k][L +: BLOCK]} + {{BLOCK{1'b0}}, 1'b1};
      assign {gc[g+1], gs[g]} = gc[g] ? s1 : s0;
    end
    always_comb begin
      sv = s_q[k];
      for (int g = 0; g < GPS; g++) sv[(k * GPS + g) * BLOCK +: BLOCK] = gs[g];
    end
    assign s_n[k] = sv;
    assign c_n[k] = gc[GPS];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSTAGES; k++) v_q[k] <= 1'b0;
      s.out_valid <= 1'b0;
      s.result    <= '0;
      s.cout      <= 1'b0;
      s.overflow  <= 1'b0;
      s.zero      <= 1'b0;
    end else if (adv) begin
      v_q[0] <= s.in_valid;
      a_q[0] <= s.a;
      b_q[0] <= s.sub ? ~s.b : s.b;
      c_q[0] <= s.sub | s.cin;
      s_q[0] <= '0;
      for (int k = 1; k < NSTAGES; k++) begin
        v_q[k] <= v_q[k-1];
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
        s_q[k] <= s_n[k-1];
        c_q[k] <= c_n[k-1];
      end
      s.out_valid <= v_q[NSTAGES-1];
      if (v_q[NSTAGES-1]) begin
        s.result   <= s_n[NSTAGES-1];
        s.cout     <= c_n[NSTAGES-1];
        s.overflow <= (a_q[NSTAGES-1][WIDTH-1] == b_q[NSTAGES-1][WIDTH-1]) &&
                      (s_n[NSTAGES-1][WIDTH-1] != a_q[NSTAGES-1][WIDTH-1]);
        s.zero     <= ~|s_n[NSTAGES-1];
      end
    end
  end
endmodule

// File: doc/pipelined_carry_select_adder.md
# pipelined_carry_select_adder

Parametrised, pipelined carry-select adder/subtractor: the operand is split into BLOCK-bit carry-select groups, and the groups are split across pipeline stages with a registered carry between stages. Add or subtract is chosen per transaction. The block accepts one operation per cycle under a valid/ready handshake and reports carry-out, signed overflow and zero. It sits in the arithmetic datapath where a single-cycle 32-bit ripple of group carries no longer meets timing.

## Interface
- WIDTH, 32: operand/result width; must be a multiple of BLOCK*GPS.
- BLOCK, 4: bits per carry-select group (two precomputed ripple sums, cin=0 and cin=1, then a mux).
- GPS, 2: groups per pipeline stage. NSTAGES = WIDTH/(BLOCK*GPS); default 4.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation present.
- in_ready  out  1  block accepts when in_valid && in_ready.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  0: a+b+cin; 1: a+~b+1 (a−b).
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- result  out  WIDTH  sum/difference, modulo 2^WIDTH.
- cout  out  1  carry out of bit WIDTH−1 (for sub: 1 = no borrow).
- overflow  out  1  signed two's-complement overflow.
- zero  out  1  result == 0.

## Operation
- On acceptance: b_eff = sub ? ~b : b, c0 = sub ? 1 : cin. Register a, b_eff, c0 and sub into stage 0.
- Stage k (0..NSTAGES−1) processes groups k*GPS .. k*GPS+GPS−1, using the carry registered from stage k−1 (c0 for k=0).
- Each group computes both sums in parallel. The incoming group carry selects the sum and carry-out; the carry chains group to group within the stage.
- Low result bits already produced are carried forward unchanged. Operand bits not yet consumed are carried forward with them.
- The last stage forms:
  - result
  - cout = final group carry
  - overflow = (a[W−1] == b_eff[W−1]) && (result[W−1] != a[W−1])
  - zero = ~|result
- Each stage holds a valid bit. Pipeline advance condition: adv = !out_valid || out_ready. When adv=0, every stage register, including valid bits, holds.
- in_ready = adv (combinational from out_valid/out_ready).
- No bubble collapsing: a stall freezes the whole pipe.
- Reset: all stage valid bits and out_valid = 0; in_ready = 1 from the first cycle after reset. result, cout, overflow and zero reset to 0. Data registers other than outputs need not reset.
- rst asserted mid-operation discards all in-flight operations. No output is produced for them.

## Timing
- Latency: an operation accepted at edge t appears with out_valid=1 after edge t+NSTAGES, i.e. 4 cycles at defaults, provided no stall occurs.
- Throughput: 1 operation/cycle when out_ready is held high.
- Outputs (result, cout, overflow, zero) are registered and remain stable while out_valid && !out_ready.
- Simultaneous out-handshake and in-handshake in the same cycle is legal. The pipe shifts by one.
- in_valid=0 while adv=1 inserts a bubble; valid bits propagate 0.
- Critical path per stage is about BLOCK full-adder ripple plus GPS mux levels. No path spans stages.
- A change to sub or cin takes effect per transaction; no cross-transaction state exists.

## Test plan
- Reset, then a=32'h0000_0001, b=32'h0000_0001, cin=0, sub=0, in_valid for 1 cycle -> out_valid exactly 4 cycles after acceptance, result=2, cout=0, overflow=0, zero=0. in_ready=1 throughout.
- Carry across every stage: a=32'hFFFF_FFFF, b=0, cin=1, sub=0 -> result=0, cout=1, zero=1, overflow=0. Also a=32'h7FFF_FFFF, b=1 -> result=32'h8000_0000, overflow=1, cout=0.
- Subtract: a=5, b=7, sub=1 (cin=1 ignored) -> result=32'hFFFF_FFFE, cout=0. Also a=32'h8000_0000, b=1, sub=1 -> result=32'h7FFF_FFFF, overflow=1, cout=1. Also a=b=32'h1234_5678 -> zero=1, cout=1.
- Back-to-back stream of 100 random ops with out_ready=1 -> one result per cycle, in order, matching the reference model ({cout,result} = a + b_eff + c0, and the overflow formula).
- Backpressure: hold out_ready=0 for 5 cycles while out_valid=1 -> in_ready=0, outputs stable, no ops lost or duplicated. On release, the queued ops drain in order, one per cycle.
- Assert rst for 1 cycle with 3 ops in flight -> out_valid=0 the next cycle and all outputs 0. None of the 3 results ever appear. A new op afterwards completes with 4-cycle latency.
- Repeat the random stream with WIDTH=16, BLOCK=4, GPS=1 (latency 4) and WIDTH=64, BLOCK=8, GPS=2 (latency 4) -> results match the model.
